// File: rtl/demux_1to16_capture.sv
// Serial-to-parallel 1:16 demux: steers accepted bits into 16 capture slots and
// presents each completed frame on a registered valid/ready output. Optional: DEMUX_1TO16_PARITY_EN.
module demux_1to16_capture #(
    parameter int N     = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic [SEL_W-1:0] sel,
    input  logic             auto,
    input  logic             clear,
    output logic [N-1:0]     data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
`ifdef DEMUX_1TO16_PARITY_EN
    output logic             out_parity,
`endif
    output logic [SEL_W-1:0] ptr
);

    typedef enum logic {EMPTY, FULL} out_state_t;

    logic [N-1:0]     cap_q, cap_d;
    logic [N-1:0]     filled_q, filled_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     data_q;
    logic             ovr_q;
    out_state_t       state_q;

    logic             accept;
    logic             complete;
    logic [SEL_W-1:0] idx;
    logic [N-1:0]     onehot;
    logic [N-1:0]     cap_new;
    logic [N-1:0]     filled_new;

    always_comb begin
        accept      = din_valid & ~clear;
        idx         = auto ? ptr_q : sel;
        onehot      = '0;
        onehot[idx] = 1'b1;
        filled_new  = filled_q | onehot;
        cap_new     = (cap_q & ~onehot) | ({N{din}} & onehot);
        complete    = accept & (&filled_new);

        cap_d    = cap_q;
        filled_d = filled_q;
        ptr_d    = ptr_q;
        if (clear) begin
            cap_d    = '0;
            filled_d = '0;
            ptr_d    = '0;
        end else if (accept) begin
            // A completing bit empties the capture side; the frame goes to the output stage.
            cap_d    = complete ? '0 : cap_new;
            filled_d = complete ? '0 : filled_new;
            if (auto)
                ptr_d = ptr_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q    <= '0;
            filled_q <= '0;
            ptr_q    <= '0;
        end else begin
            cap_q    <= cap_d;
            filled_q <= filled_d;
            ptr_q    <= ptr_d;
        end
    end

`ifdef DEMUX_1TO16_PARITY_EN
    logic par_q;
    assign out_parity = par_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ovr_q   <= 1'b0;
`ifdef DEMUX_1TO16_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (complete) begin
                        data_q  <= cap_new;
`ifdef DEMUX_1TO16_PARITY_EN
                        par_q   <= ^cap_new;
`endif
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (complete) begin
                        // Replace only if the held frame leaves on this same edge.
                        if (out_ready) begin
                            data_q <= cap_new;
`ifdef DEMUX_1TO16_PARITY_EN
                            par_q  <= ^cap_new;
`endif
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign data_out  = data_q;
    assign out_valid = (state_q == FULL);
    assign overrun   = ovr_q;
    assign ptr       = ptr_q;

endmodule
